// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter with repeat count and gap; parity bit via SEQ_PATTERN_TX_PARITY_EN
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int CNT_W = 4,
    parameter int GAP_CYC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam int BW = PAT_W > 1 ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] BIT_LD = BW'(PAT_W - 1);
    localparam logic [3:0] GAP_LD = 4'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    state_t state;
    logic [PAT_W-1:0] shreg;
    logic [BW-1:0] bit_cnt;
    logic [CNT_W-1:0] reps_left;
    logic [3:0] gap_cnt;
    logic rep_end;
`ifdef SEQ_PATTERN_TX_PARITY_EN
    logic par_ph;
    assign rep_end = par_ph;
`else
    assign rep_end = bit_cnt == '0;
`endif
    // shreg holds the bits still to come; out already carries the current bit
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            bit_cnt <= '0;
            reps_left <= '0;
            gap_cnt <= '0;
            out <= 1'b0;
            out_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_ph <= 1'b0;
`endif
        end else if (abort) begin
            state <= IDLE;
            out <= 1'b0;
            out_valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_ph <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    reps_left <= repeat_n == '0 ? CNT_W'(1) : repeat_n;
                    shreg <= PATTERN << 1;
                    bit_cnt <= BIT_LD;
                    out <= PATTERN[PAT_W-1];
                    out_valid <= 1'b1;
                    busy <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: if (rep_end) begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
                    par_ph <= 1'b0;
`endif
                    if (reps_left == CNT_W'(1)) begin
                        state <= DONE;
                        out <= 1'b0;
                        out_valid <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        reps_left <= reps_left - 1'b1;
                        if (GAP_CYC > 0) begin
                            state <= GAP;
                            gap_cnt <= GAP_LD;
                            out <= 1'b0;
                            out_valid <= 1'b0;
                        end else begin
                            shreg <= PATTERN << 1;
                            bit_cnt <= BIT_LD;
                            out <= PATTERN[PAT_W-1];
                        end
                    end
                end
`ifdef SEQ_PATTERN_TX_PARITY_EN
                else if (bit_cnt == '0) begin
                    par_ph <= 1'b1;
                    out <= ^PATTERN;
                end
`endif
                else begin
                    out <= shreg[PAT_W-1];
                    shreg <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                end
                GAP: if (gap_cnt == '0) begin
                    shreg <= PATTERN << 1;
                    bit_cnt <= BIT_LD;
                    out <= PATTERN[PAT_W-1];
                    out_valid <= 1'b1;
                    state <= SHIFT;
                end else begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
